// File: rtl/core_iaddr_mmu_if.sv
// core_iaddr_mmu_if: fetch-MMU to main-TLB lookup channel; the response is valid in the handshake cycle.
interface core_iaddr_mmu_if;
  logic        req_valid;
  logic [19:0] req_vppn;
  logic        req_ready;
  logic        resp_found;
  logic        resp_v;
  logic [1:0]  resp_plv;
  logic [1:0]  resp_mat;
  logic [19:0] resp_ppn;
  modport master (output req_valid, req_vppn, input req_ready, resp_found, resp_v, resp_plv, resp_mat, resp_ppn);
  modport slave (input req_valid, req_vppn, output req_ready, resp_found, resp_v, resp_plv, resp_mat, resp_ppn);
endinterface

// File: rtl/core_iaddr_mmu.sv
// core_iaddr_mmu: instruction-fetch address translation (DA, DMW, micro-TLB) with main-TLB refill.
module core_iaddr_mmu #(
  parameter int ENABLE_TLB   = 1,
  parameter int UTLB_ENTRIES = 4,
  parameter int NUM_DMW      = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   valid_i,
  input  logic [31:0]            vaddr_i,
  input  logic                   stall_i,
  output logic                   ready_o,
  output logic                   valid_o,
  output logic [31:0]            paddr_o,
  output logic                   uncached_o,
  output logic                   excp_adef_o,
  output logic                   excp_tlbr_o,
  output logic                   excp_pif_o,
  output logic                   excp_ppi_o,
  input  logic                   crmd_da_i,
  input  logic [1:0]             crmd_datf_i,
  input  logic [1:0]             crmd_plv_i,
  input  logic [NUM_DMW-1:0]     dmw_plv0_i,
  input  logic [NUM_DMW-1:0]     dmw_plv3_i,
  input  logic [3*NUM_DMW-1:0]   dmw_vseg_i,
  input  logic [3*NUM_DMW-1:0]   dmw_pseg_i,
  input  logic [2*NUM_DMW-1:0]   dmw_mat_i,
  input  logic                   flush_i,
  core_iaddr_mmu_if.master       tlb
);
  localparam int PW = $clog2(UTLB_ENTRIES);
  localparam bit TLB_ON = (ENABLE_TLB != 0);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t state_q, state_d;
  logic [UTLB_ENTRIES-1:0] e_val_q, e_pv_q;
  logic [19:0] e_vppn_q [UTLB_ENTRIES];
  logic [19:0] e_ppn_q [UTLB_ENTRIES];
  logic [1:0]  e_plv_q [UTLB_ENTRIES];
  logic [1:0]  e_mat_q [UTLB_ENTRIES];
  logic [PW-1:0] ptr_q, u_idx;
  logic pend_q, valid_q, unc_q, unc_d;
  logic [19:0] pend_vppn_q, req_vppn_q;
  logic [31:0] paddr_q, paddr_d;
  logic [3:0] excp_q, excp_d;
  logic dmw_hit, u_hit, mis, unmapped, use_p, miss, hs, upd;
  logic [2:0] dmw_pseg;
  logic [1:0] dmw_mat;
  always_comb begin
    dmw_hit = 1'b0;
    dmw_pseg = '0;
    dmw_mat = '0;
    for (int i = NUM_DMW - 1; i >= 0; i--)
      if (((dmw_plv0_i[i] && crmd_plv_i == 2'd0) || (dmw_plv3_i[i] && crmd_plv_i == 2'd3)) &&
          dmw_vseg_i[3*i+:3] == vaddr_i[31:29]) begin
        dmw_hit = 1'b1;
        dmw_pseg = dmw_pseg_i[3*i+:3];
        dmw_mat = dmw_mat_i[2*i+:2];
      end
    u_hit = 1'b0;
    u_idx = '0;
    for (int i = UTLB_ENTRIES - 1; i >= 0; i--)
      if (e_val_q[i] && e_vppn_q[i] == vaddr_i[31:12]) begin
        u_hit = 1'b1;
        u_idx = PW'(i);
      end
  end
  assign mis      = |vaddr_i[1:0];
  assign unmapped = !mis && !crmd_da_i && !dmw_hit && !u_hit;
  assign use_p    = unmapped && pend_q && pend_vppn_q == vaddr_i[31:12];
  assign miss     = unmapped && !use_p;
  assign ready_o  = !(valid_i && miss && TLB_ON);
  assign upd      = !stall_i && ready_o;
  assign hs       = state_q == WAIT && tlb.req_ready;
  assign tlb.req_valid = state_q == WAIT;
  assign tlb.req_vppn  = req_vppn_q;
  always_comb begin
    paddr_d = (!mis && !crmd_da_i && dmw_hit) ? {dmw_pseg, vaddr_i[28:0]} :
              (!mis && !crmd_da_i && u_hit) ? {e_ppn_q[u_idx], vaddr_i[11:0]} : vaddr_i;
    unc_d = mis ? 1'b0 : crmd_da_i ? crmd_datf_i != 2'd1 : dmw_hit ? dmw_mat != 2'd1 :
            u_hit ? e_mat_q[u_idx] != 2'd1 : 1'b0;
    // {adef, tlbr, pif, ppi}; the path select makes them mutually exclusive
    excp_d = {4{valid_i}} & {mis || (miss && !TLB_ON), use_p,
                             !mis && !crmd_da_i && !dmw_hit && u_hit && !e_pv_q[u_idx],
                             !mis && !crmd_da_i && !dmw_hit && u_hit && e_pv_q[u_idx] && crmd_plv_i > e_plv_q[u_idx]};
    state_d = flush_i ? IDLE :
              (state_q == IDLE && valid_i && miss && TLB_ON) ? WAIT :
              hs ? IDLE : state_q;
  end
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      paddr_q <= '0;
      unc_q <= 1'b0;
      excp_q <= '0;
      e_val_q <= '0;
      ptr_q <= '0;
      pend_q <= 1'b0;
    end else begin
      if (upd) begin
        valid_q <= valid_i;
        paddr_q <= paddr_d;
        unc_q <= unc_d;
        excp_q <= excp_d;
      end
      if (state_q == IDLE && state_d == WAIT) req_vppn_q <= vaddr_i[31:12];
      if (flush_i) begin
        e_val_q <= '0;
        pend_q <= 1'b0;
      end else begin
        if (hs && tlb.resp_found) begin
          e_val_q[ptr_q] <= 1'b1;
          e_pv_q[ptr_q] <= tlb.resp_v;
          e_vppn_q[ptr_q] <= req_vppn_q;
          e_ppn_q[ptr_q] <= tlb.resp_ppn;
          e_plv_q[ptr_q] <= tlb.resp_plv;
          e_mat_q[ptr_q] <= tlb.resp_mat;
          ptr_q <= ptr_q + 1'b1;
        end
        if (hs && !tlb.resp_found) begin
          pend_q <= 1'b1;
          pend_vppn_q <= req_vppn_q;
        end else if (upd && valid_i && use_p) pend_q <= 1'b0;
      end
    end
  end
  assign valid_o = valid_q;
  assign paddr_o = paddr_q;
  assign uncached_o = unc_q;
  assign {excp_adef_o, excp_tlbr_o, excp_pif_o, excp_ppi_o} = excp_q;
endmodule

// File: tb/tb_core_iaddr_mmu.sv
// tb_core_iaddr_mmu: directed checks of DA/DMW/uTLB translation, refill, tlbr, flush and eviction.
module tb_core_iaddr_mmu;
  logic clk = 1'b0, rst, valid, stall, da, flush;
  logic [31:0] vaddr;
  logic [1:0] datf, plv, p0, p3;
  logic [5:0] vseg, pseg;
  logic [3:0] mat;
  logic ready0, valid0, unc0, adef0, tlbr0, pif0, ppi0;
  logic ready1, valid1, unc1, adef1, tlbr1, pif1, ppi1;
  logic [31:0] paddr0, paddr1;
  int tests = 0, fails = 0;
  core_iaddr_mmu_if tif();
  core_iaddr_mmu_if tif1();
  always #5 clk = ~clk;
  core_iaddr_mmu u0 (.clk(clk), .rst(rst), .valid_i(valid), .vaddr_i(vaddr), .stall_i(stall),
    .ready_o(ready0), .valid_o(valid0), .paddr_o(paddr0), .uncached_o(unc0),
    .excp_adef_o(adef0), .excp_tlbr_o(tlbr0), .excp_pif_o(pif0), .excp_ppi_o(ppi0),
    .crmd_da_i(da), .crmd_datf_i(datf), .crmd_plv_i(plv), .dmw_plv0_i(p0), .dmw_plv3_i(p3),
    .dmw_vseg_i(vseg), .dmw_pseg_i(pseg), .dmw_mat_i(mat), .flush_i(flush), .tlb(tif));
  core_iaddr_mmu #(.ENABLE_TLB(0)) u1 (.clk(clk), .rst(rst), .valid_i(valid), .vaddr_i(vaddr), .stall_i(stall),
    .ready_o(ready1), .valid_o(valid1), .paddr_o(paddr1), .uncached_o(unc1),
    .excp_adef_o(adef1), .excp_tlbr_o(tlbr1), .excp_pif_o(pif1), .excp_ppi_o(ppi1),
    .crmd_da_i(da), .crmd_datf_i(datf), .crmd_plv_i(plv), .dmw_plv0_i(p0), .dmw_plv3_i(p3),
    .dmw_vseg_i(vseg), .dmw_pseg_i(pseg), .dmw_mat_i(mat), .flush_i(flush), .tlb(tif1));
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic wait_req();
    for (int k = 0; k < 8 && tif.req_valid !== 1'b1; k++) tick();
    chk("req_wait", {31'd0, tif.req_valid}, 32'd1);
  endtask
  task automatic respond(input logic f, input logic v, input logic [1:0] pl, input logic [1:0] m, input logic [19:0] ppn);
    tif.resp_found = f;
    tif.resp_v = v;
    tif.resp_plv = pl;
    tif.resp_mat = m;
    tif.resp_ppn = ppn;
    tif.req_ready = 1'b1;
    tick();
    tif.req_ready = 1'b0;
    tif.resp_found = 1'b0;
    #1;
  endtask
  task automatic fill(input logic [31:0] va, input logic f, input logic v, input logic [1:0] pl,
                      input logic [1:0] m, input logic [19:0] ppn);
    vaddr = va;
    valid = 1'b1;
    wait_req();
    chk("req_vppn", {12'd0, tif.req_vppn}, {12'd0, va[31:12]});
    respond(f, v, pl, m, ppn);
  endtask
  initial begin
    {valid, stall, da, flush, datf, plv, p0, p3, vseg, pseg, mat} = '0;
    vaddr = '0;
    {tif.req_ready, tif.resp_found, tif.resp_v, tif.resp_plv, tif.resp_mat, tif.resp_ppn} = '0;
    {tif1.req_ready, tif1.resp_found, tif1.resp_v, tif1.resp_plv, tif1.resp_mat, tif1.resp_ppn} = '0;
    rst = 1'b1;
    tick();
    tick();
    chk("rst_valid", {31'd0, valid0}, 32'd0);
    chk("rst_paddr", paddr0, 32'd0);
    chk("rst_unc_excp", {27'd0, unc0, adef0, tlbr0, pif0, ppi0}, 32'd0);
    chk("rst_req", {31'd0, tif.req_valid}, 32'd0);
    rst = 1'b0;
    da = 1'b1; datf = 2'd1; vaddr = 32'h1C000000; valid = 1'b1;
    #1 chk("da_ready", {31'd0, ready0}, 32'd1);
    tick();
    chk("da_valid", {31'd0, valid0}, 32'd1);
    chk("da_paddr", paddr0, 32'h1C000000);
    chk("da_unc", {31'd0, unc0}, 32'd0);
    datf = 2'd0;
    tick();
    chk("da_unc_datf0", {31'd0, unc0}, 32'd1);
    stall = 1'b1; vaddr = 32'h1C001000; datf = 2'd1;
    tick();
    chk("stall_paddr", paddr0, 32'h1C000000);
    chk("stall_unc", {31'd0, unc0}, 32'd1);
    stall = 1'b0;
    da = 1'b0; p0 = 2'b01; vseg = {3'd5, 3'd5}; pseg = {3'd3, 3'd0}; mat = {2'd1, 2'd0};
    vaddr = 32'hA0001000;
    tick();
    chk("dmw0_paddr", paddr0, 32'h00001000);
    chk("dmw0_unc", {31'd0, unc0}, 32'd1);
    chk("dmw0_noreq", {31'd0, tif.req_valid}, 32'd0);
    plv = 2'd3; p3 = 2'b10;
    tick();
    chk("dmw1_paddr", paddr0, 32'h60001000);
    chk("dmw1_unc", {31'd0, unc0}, 32'd0);
    plv = 2'd0; p0 = 2'b00; p3 = 2'b00;
    vaddr = 32'h00402004;
    #1 chk("miss_ready", {31'd0, ready0}, 32'd0);
    chk("notlb_ready", {31'd0, ready1}, 32'd1);
    tick();
    chk("miss_req", {31'd0, tif.req_valid}, 32'd1);
    chk("miss_vppn", {12'd0, tif.req_vppn}, 32'h00402);
    chk("notlb_adef", {28'd0, adef1, tlbr1, pif1, ppi1}, 32'b1000);
    chk("notlb_noreq", {31'd0, tif1.req_valid}, 32'd0);
    respond(1'b1, 1'b1, 2'd3, 2'd1, 20'h12345);
    chk("fill_ready", {31'd0, ready0}, 32'd1);
    chk("fill_req_done", {31'd0, tif.req_valid}, 32'd0);
    tick();
    chk("hit_paddr", paddr0, 32'h12345004);
    chk("hit_unc_excp", {27'd0, unc0, adef0, tlbr0, pif0, ppi0}, 32'd0);
    tick();
    chk("hit_repeat_noreq", {31'd0, tif.req_valid}, 32'd0);
    plv = 2'd3;
    fill(32'h00403000, 1'b1, 1'b1, 2'd0, 2'd0, 20'h0ABCD);
    tick();
    chk("ppi_paddr", paddr0, 32'h0ABCD000);
    chk("ppi_unc_excp", {27'd0, unc0, adef0, tlbr0, pif0, ppi0}, 32'b10001);
    fill(32'h00404008, 1'b1, 1'b0, 2'd3, 2'd1, 20'h00777);
    tick();
    chk("pif_paddr", paddr0, 32'h00777008);
    chk("pif_excp", {28'd0, adef0, tlbr0, pif0, ppi0}, 32'b0010);
    plv = 2'd0;
    fill(32'h00405000, 1'b0, 1'b0, 2'd0, 2'd0, 20'h0);
    chk("pend_ready", {31'd0, ready0}, 32'd1);
    tick();
    chk("tlbr_valid", {31'd0, valid0}, 32'd1);
    chk("tlbr_excp", {28'd0, adef0, tlbr0, pif0, ppi0}, 32'b0100);
    chk("tlbr_consumed", {31'd0, ready0}, 32'd0);
    tick();
    chk("refetch_req", {31'd0, tif.req_valid}, 32'd1);
    chk("refetch_vppn", {12'd0, tif.req_vppn}, 32'h00405);
    respond(1'b1, 1'b1, 2'd3, 2'd1, 20'h00055);
    tick();
    chk("refetch_paddr", paddr0, 32'h00055000);
    vaddr = 32'h00406000;
    wait_req();
    flush = 1'b1;
    respond(1'b1, 1'b1, 2'd3, 2'd1, 20'h00066);
    flush = 1'b0;
    #1 chk("flush_nofill", {31'd0, ready0}, 32'd0);
    vaddr = 32'h00402004;
    #1 chk("flush_inval", {31'd0, ready0}, 32'd0);
    valid = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    vaddr = 32'h1C000002; valid = 1'b1;
    #1 chk("mis_ready", {31'd0, ready0}, 32'd1);
    tick();
    chk("mis_adef", {28'd0, adef0, tlbr0, pif0, ppi0}, 32'b1000);
    chk("mis_noreq", {31'd0, tif.req_valid}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      fill(32'h10000000 + 32'(i << 12), 1'b1, 1'b1, 2'd3, 2'd1, 20'(32'h20000 + i));
      tick();
    end
    vaddr = 32'h10001000;
    #1 chk("evict_keep_ready", {31'd0, ready0}, 32'd1);
    tick();
    chk("evict_keep_paddr", paddr0, 32'h20001000);
    vaddr = 32'h10000000;
    #1 chk("evict_first_miss", {31'd0, ready0}, 32'd0);
    tick();
    chk("evict_req", {31'd0, tif.req_valid}, 32'd1);
    tif.resp_found = 1'b1; tif.resp_v = 1'b1; tif.resp_ppn = 20'h2AAAA; tif.req_ready = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0; tif.req_ready = 1'b0; tif.resp_found = 1'b0;
    #1 chk("rstwait_req", {31'd0, tif.req_valid}, 32'd0);
    chk("rstwait_valid", {31'd0, valid0}, 32'd0);
    chk("rstwait_nofill", {31'd0, ready0}, 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
